// File: rtl/mp_dot_mac.sv
// Multi-lane signed dot-product accumulator: 3-stage pipeline (products, lane sum, frame accumulate).
// Define MP_DOT_MAC_SAT_EN to clamp the accumulator on overflow; otherwise it wraps modulo 2^AW.
module mp_dot_mac #(
  parameter int unsigned LANES = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic [LANES*DW-1:0]   a,
  input  logic [LANES*DW-1:0]   b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [AW-1:0]         out_acc,
  output logic                  out_ovf
);

  if (AW < 2*DW + $clog2(LANES)) begin : g_bad_aw
    $error("mp_dot_mac: AW must be at least 2*DW + clog2(LANES)");
  end
  if (LANES == 0 || (LANES & (LANES - 1)) != 0) begin : g_bad_lanes
    $error("mp_dot_mac: LANES must be a nonzero power of two");
  end

  typedef enum logic {IDLE, ACCUM} state_t;

  logic                   stall;
  logic                   s1_v, s1_first, s1_last;
  logic signed [2*DW-1:0] prod [LANES];
  logic signed [AW-1:0]   sum_c;
  logic                   s2_v, s2_first, s2_last;
  logic [AW-1:0]          sum;
  state_t                 state, state_n;
  logic [AW-1:0]          acc, acc_n, base;
  logic                   ovf, ovf_n, base_ovf;
  logic [AW:0]            wide;
  logic                   wrap_ovf, restart, step;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign step     = s2_v && !stall;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_v     <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      for (int unsigned i = 0; i < LANES; i++) prod[i] <= '0;
    end else if (!stall) begin
      s1_v     <= in_valid;
      s1_first <= in_first;
      s1_last  <= in_last;
      for (int unsigned i = 0; i < LANES; i++)
        prod[i] <= $signed(a[i*DW +: DW]) * $signed(b[i*DW +: DW]);
    end
  end

  always_comb begin
    sum_c = '0;
    for (int unsigned i = 0; i < LANES; i++) sum_c = sum_c + AW'(prod[i]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_v     <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      sum      <= '0;
    end else if (!stall) begin
      s2_v     <= s1_v;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      sum      <= sum_c;
    end
  end

  // IDLE ignores in_first: every beat arriving in IDLE opens a frame.
  always_comb begin
    restart  = (state == IDLE) || s2_first;
    base     = restart ? '0 : acc;
    base_ovf = restart ? 1'b0 : ovf;
    wide     = {base[AW-1], base} + {sum[AW-1], sum};
    wrap_ovf = wide[AW] ^ wide[AW-1];
`ifdef MP_DOT_MAC_SAT_EN
    if (wrap_ovf) acc_n = wide[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    else          acc_n = wide[AW-1:0];
`else
    acc_n = wide[AW-1:0];
`endif
    ovf_n   = base_ovf | wrap_ovf;
    state_n = state;
    if (step) state_n = s2_last ? IDLE : ACCUM;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      if (step) begin
        acc <= acc_n;
        ovf <= ovf_n;
      end
    end
  end

  // Not stalled means the held result is absent or consumed now, so a new one may replace it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_ovf   <= 1'b0;
    end else if (!stall) begin
      out_valid <= s2_v && s2_last;
      if (s2_v && s2_last) begin
        out_acc <= acc_n;
        out_ovf <= ovf_n;
      end
    end
  end

endmodule

// File: tb/tb_mp_dot_mac.sv
// Directed self-checking bench for mp_dot_mac: one-beat vector table plus multi-cycle framing,
// backpressure, overflow (AW=18 instance) and reset sequences.
module tb_mp_dot_mac;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid, in_first, in_last, out_ready;
  logic [31:0] a, b;
  logic        in_ready, out_valid, out_ovf;
  logic [31:0] out_acc;
  logic        in_ready18, out_valid18, out_ovf18;
  logic [17:0] out_acc18;

  int checks = 0;
  int failures = 0;
  logic mon_en = 1'b0;
  longint got_q[$];

  always #5 clk = ~clk;

  mp_dot_mac #(.LANES(4), .DW(8), .AW(32)) u_dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .out_ovf(out_ovf));

  mp_dot_mac #(.LANES(4), .DW(8), .AW(18)) u_dut18 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready18),
    .in_first(in_first), .in_last(in_last), .a(a), .b(b),
    .out_valid(out_valid18), .out_ready(out_ready), .out_acc(out_acc18), .out_ovf(out_ovf18));

  always @(negedge clk)
    if (mon_en && out_valid && out_ready) got_q.push_back(longint'($signed(out_acc)));

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    longint      acc;
    logic        ovf;
  } vec_t;

  function automatic logic [31:0] pk(input int x0, input int x1, input int x2, input int x3);
    logic [31:0] r;
    r[7:0] = x0[7:0]; r[15:8] = x1[7:0]; r[23:16] = x2[7:0]; r[31:24] = x3[7:0];
    return r;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [31:0] av, input logic [31:0] bv,
                       input logic f, input logic l, input logic v);
    a = av; b = bv; in_first = f; in_last = l; in_valid = v;
  endtask

  // Offers one beat, waits (bounded) for acceptance, returns #1 after the accepting edge.
  task automatic beat(input logic [31:0] av, input logic [31:0] bv, input logic f, input logic l);
    int unsigned n = 0;
    drive(av, bv, f, l, 1'b1);
    while (!in_ready && n < 50) begin step(); n++; end
    if (!in_ready) chk("beat_accept_timeout", 0, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic expect_result(input string name, input longint exp, input logic exp_ovf);
    step();
    chk({name, "_early"}, longint'(out_valid), 0);
    step();
    chk({name, "_valid"}, longint'(out_valid), 1);
    chk({name, "_acc"}, longint'($signed(out_acc)), exp);
    chk({name, "_ovf"}, longint'(out_ovf), longint'(exp_ovf));
  endtask

  vec_t vecs[6];
  logic [31:0] v1a, v1b, m128, p127;
  longint exp_ovf_acc;

  initial begin
    v1a  = pk(1, 2, 3, 4);
    v1b  = pk(5, 6, 7, 8);
    m128 = pk(-128, -128, -128, -128);
    p127 = pk(127, 127, 127, 127);
    vecs[0] = '{v1a, v1b, 70, 1'b0};
    vecs[1] = '{m128, m128, 65536, 1'b0};
    vecs[2] = '{m128, p127, -65024, 1'b0};
    vecs[3] = '{pk(-1, 2, -3, 4), pk(5, -6, 7, -8), -70, 1'b0};
    vecs[4] = '{p127, p127, 64516, 1'b0};
    vecs[5] = '{pk(0, 0, 0, 0), m128, 0, 1'b0};
`ifdef MP_DOT_MAC_SAT_EN
    exp_ovf_acc = 131071;
`else
    exp_ovf_acc = -65536;
`endif

    rstn = 1'b0; out_ready = 1'b1;
    drive('0, '0, 1'b0, 1'b0, 1'b0);
    #12;
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_acc", longint'($signed(out_acc)), 0);
    chk("rst_out_ovf", longint'(out_ovf), 0);
    rstn = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      beat(vecs[i].va, vecs[i].vb, 1'b1, 1'b1);
      expect_result("table", vecs[i].acc, vecs[i].ovf);
      step();
    end

    // three-beat frame back to back, then a one-beat frame on the very next cycle
    drive(v1a, v1b, 1'b1, 1'b0, 1'b1); step();
    drive(v1a, v1b, 1'b0, 1'b0, 1'b1); step();
    chk("b2b_t1_valid", longint'(out_valid), 0);
    drive(v1a, v1b, 1'b0, 1'b1, 1'b1); step();
    chk("b2b_t2_valid", longint'(out_valid), 0);
    drive(v1a, v1b, 1'b1, 1'b1, 1'b1); step();
    chk("b2b_t3_valid", longint'(out_valid), 0);
    in_valid = 1'b0; step();
    chk("b2b_t4_valid", longint'(out_valid), 1);
    chk("b2b_t4_acc", longint'($signed(out_acc)), 210);
    step();
    chk("b2b_t5_valid", longint'(out_valid), 1);
    chk("b2b_t5_acc", longint'($signed(out_acc)), 70);
    step();
    chk("b2b_t6_valid", longint'(out_valid), 0);

    // backpressure: results must come out in order, none lost or duplicated
    got_q.delete(); mon_en = 1'b1; out_ready = 1'b0;
    beat(v1a, v1b, 1'b1, 1'b1);
    beat(vecs[3].va, vecs[3].vb, 1'b1, 1'b1);
    beat(m128, m128, 1'b1, 1'b1);
    drive(m128, p127, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_in_ready", longint'(in_ready), 0);
      chk("bp_hold_valid", longint'(out_valid), 1);
      chk("bp_hold_acc", longint'($signed(out_acc)), 70);
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) step();
    mon_en = 1'b0;
    chk("bp_count", longint'(got_q.size()), 4);
    begin
      longint exp_seq[4] = '{70, -70, 65536, -65024};
      for (int k = 0; k < 4; k++)
        chk("bp_order", (k < got_q.size()) ? got_q[k] : 64'hdead, exp_seq[k]);
    end

    // overflow on the AW=18 instance: three beats of 65536
    beat(m128, m128, 1'b1, 1'b0);
    beat(m128, m128, 1'b0, 1'b0);
    beat(m128, m128, 1'b0, 1'b1);
    step(); step();
    chk("ovf18_valid", longint'(out_valid18), 1);
    chk("ovf18_acc", longint'($signed(out_acc18)), exp_ovf_acc);
    chk("ovf18_ovf", longint'(out_ovf18), 1);
    chk("ovf32_acc", longint'($signed(out_acc)), 196608);
    chk("ovf32_ovf", longint'(out_ovf), 0);
    step();
    beat(v1a, v1b, 1'b1, 1'b1);
    step(); step();
    chk("ovf18_next_acc", longint'($signed(out_acc18)), 70);
    chk("ovf18_next_ovf", longint'(out_ovf18), 0);
    step();

    // asynchronous reset mid-frame with a result on the output
    beat(v1a, v1b, 1'b1, 1'b1);
    beat(m128, m128, 1'b1, 1'b0);
    beat(m128, m128, 1'b0, 1'b0);
    chk("rst_pre_valid", longint'(out_valid), 1);
    rstn = 1'b0;
    #2;
    chk("rst_mid_valid", longint'(out_valid), 0);
    chk("rst_mid_acc", longint'($signed(out_acc)), 0);
    chk("rst_mid_ovf", longint'(out_ovf), 0);
    chk("rst_mid_in_ready", longint'(in_ready), 1);
    #3 rstn = 1'b1;
    step();
    beat(v1a, v1b, 1'b1, 1'b1);
    expect_result("post_rst", 70, 1'b0);
    step();

    // in_first mid-frame discards the partial sum
    beat(m128, m128, 1'b1, 1'b0);
    beat(m128, m128, 1'b0, 1'b0);
    beat(v1a, v1b, 1'b1, 1'b0);
    beat(v1a, v1b, 1'b0, 1'b1);
    expect_result("restart", 140, 1'b0);
    step();

    // frame opened in IDLE without in_first
    beat(v1a, v1b, 1'b0, 1'b0);
    beat(v1a, v1b, 1'b0, 1'b1);
    expect_result("idle_nofirst", 140, 1'b0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mp_dot_mac.md
# mp_dot_mac

Parametrised multi-lane signed dot-product accumulator, the successor to the single-lane int8 MAC in the mixed-precision core. Each accepted beat multiplies `LANES` pairs of signed `DW`-bit operands, reduces them through a registered adder tree and accumulates into an internal `AW`-bit accumulator. Beats are grouped into frames; one result is emitted per frame over a valid/ready handshake. It sits between the operand fetch/buffer stage and the writeback/requant stage.

## Interface
- `LANES`, 4: number of multiplier lanes, ≥1, power of two.
- `DW`, 8: operand width in bits, signed two's complement.
- `AW`, 32: accumulator and result width. Must satisfy AW ≥ 2·DW + clog2(LANES); elaboration fails otherwise.

- `clk`  in  1  clock, all state on rising edge.
- `rstn`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  beat offered.
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`.
- `in_first`  in  1  beat opens a new frame.
- `in_last`  in  1  beat closes the frame.
- `a`  in  LANES·DW  lane i operand at bits [i·DW +: DW].
- `b`  in  LANES·DW  lane i operand at bits [i·DW +: DW].
- `out_valid`  out  1  result available.
- `out_ready`  in  1  result consumed when `out_valid && out_ready`.
- `out_acc`  out  AW  signed frame result.
- `out_ovf`  out  1  overflow occurred anywhere in the frame (sticky per frame).

## Operation
- S1 registers the LANES signed products, 2·DW bits each. S2 registers their sign-extended sum at AW bits. S3 updates the accumulator and frame state.
- Frame FSM, evaluated when a beat reaches S3:
  - IDLE: any beat starts a new frame. `acc = sum` and `ovf = 0`. The beat's `in_first` is ignored here, so a beat without `in_first` still starts a new frame. Go to ACCUM, or emit if the beat is last.
  - ACCUM: `in_first` restarts the frame (`acc = sum`, `ovf = 0`) and the partial result is discarded. Otherwise `acc = acc + sum`.
  - A last beat loads `out_acc`/`out_ovf`, sets `out_valid` and returns to IDLE. `in_first && in_last` is a one-beat frame.
- Accumulate arithmetic uses AW+1 bits. Signed overflow occurs when the result does not fit in AW bits; it sets `ovf`. Saturating or wrapping behaviour is set by the macro below.
- Stall: `stall = out_valid && !out_ready`; `in_ready = !stall`.
  - While stalled, all pipeline stages, the accumulator and the FSM hold.
  - If a last beat reaches S3 in the same cycle that `out_valid && out_ready`, the new result replaces the old one, with no bubble.
- Reset: asserting `rstn` low at any point clears all stage valids, `acc`, `ovf`, `out_acc` and `out_ovf` to 0, sets `out_valid` to 0 and the FSM to IDLE, immediately and asynchronously. Any in-flight frame is lost.

## Timing
- Beat accepted at edge t: products are in S1 after t, sum in S2 after t+1, accumulate at t+2. A last beat raises `out_valid` after edge t+2, i.e. result visible in cycle t+3. Latency is 3 cycles, measured with no stall.
- Throughput is one beat per cycle with `out_ready` held high.
- Reset values: `in_ready` = 1, `out_valid` = 0, `out_acc` = 0, `out_ovf` = 0.
- `out_acc` and `out_ovf` are stable while `out_valid && !out_ready`.

## Configuration
- `MP_DOT_MAC_SAT_EN` defined: on overflow the accumulator clamps to +(2^(AW−1)−1) or −2^(AW−1), by the sign of the true sum, and further beats accumulate from the clamped value. `out_ovf` = 1.
- Undefined: the accumulator wraps modulo 2^AW. `out_ovf` still reports that a wrap occurred. The saturation logic is not built.

## Test plan
All scenarios use LANES=4 and DW=8.

- **One-beat frame**, AW=32: a={1,2,3,4}, b={5,6,7,8}, first+last → `out_acc`=70 in cycle t+3, `out_ovf`=0.
- **Signed extremes**, one-beat frames: all a=−128, b=−128 → 65536; all a=−128, b=127 → −65024.
- **Three-beat back-to-back frame**: scenario-1 operands on every beat, `out_ready`=1 → `out_acc`=210, `out_valid` high for exactly one cycle. Then a one-beat frame offered the next cycle → 70 three cycles later.
- **Backpressure**: hold `out_ready`=0 after a result → `in_ready`=0 and the pipeline frozen. Release after 5 cycles → results delivered in order, none lost or duplicated.
- **Overflow**, AW=18: three beats each summing to 65536.
  - With `MP_DOT_MAC_SAT_EN`: `out_acc`=131071, `out_ovf`=1.
  - Without: `out_acc`=−65536, `out_ovf`=1.
  - The next frame has `out_ovf`=0.
- **Reset and framing edge cases**:
  - `rstn` low mid-frame → `out_valid`=0 and `out_acc`=0 at once. After release, a one-beat frame → 70.
  - `in_first` mid-frame → the prior partial sum is discarded.
  - A beat with no `in_first` while in IDLE → starts a frame.
